// File: rtl/attack2_hit_detector_if.sv
// Bus between the X-key projectile, the enemy bank and attack2_hit_detector.
// The detector uses the slave modport; the projectile/enemy-bank side uses master.
interface attack2_hit_detector_if #(
    parameter int IDX_W = 3
) ();
    logic             game_frame_clk_rising_edge;
    logic             Obj_On;
    logic [8:0]       Obj_X_Pos;
    logic [8:0]       Obj_Y_Pos;
    logic [3:0]       Game_Level;
    logic [IDX_W-1:0] Enemy_Idx;
    logic [8:0]       Enemy_X;
    logic [8:0]       Enemy_Y;
    logic             Enemy_Alive;
    logic             One_Enemy_Is_Attacked2;
    logic             Enemy_Hit_Valid;
    logic [IDX_W-1:0] Enemy_Hit_Idx;
    logic [4:0]       Enemy_Damage;
    logic [15:0]      Score;

    modport master (
        output game_frame_clk_rising_edge, Obj_On, Obj_X_Pos, Obj_Y_Pos, Game_Level,
        output Enemy_X, Enemy_Y, Enemy_Alive,
        input  Enemy_Idx, One_Enemy_Is_Attacked2, Enemy_Hit_Valid, Enemy_Hit_Idx,
        input  Enemy_Damage, Score
    );

    modport slave (
        input  game_frame_clk_rising_edge, Obj_On, Obj_X_Pos, Obj_Y_Pos, Game_Level,
        input  Enemy_X, Enemy_Y, Enemy_Alive,
        output Enemy_Idx, One_Enemy_Is_Attacked2, Enemy_Hit_Valid, Enemy_Hit_Idx,
        output Enemy_Damage, Score
    );
endinterface

// File: rtl/attack2_hit_detector.sv
// Per-frame projectile vs. enemy-bank collision scan; first hit pulses once and issues one damage command.
// Optional HIT_SCORE_EN builds a saturating accumulated-damage Score register.
module attack2_hit_detector #(
    parameter int NUM_ENEMIES = 8,
    parameter int IDX_W       = 3,
    parameter int PROJ_SIZE   = 25,
    parameter int ENEMY_SIZE  = 20,
    parameter int DAMAGE_BASE = 1
) (
    input logic                    Clk,
    input logic                    Reset,
    attack2_hit_detector_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2,
        LOCK   = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENEMIES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             pulse_q, pulse_d;
    logic [4:0]       dmg_q, dmg_d;

    logic [9:0] ox_s, oy_s, ex_s, ey_s;
    logic       overlap_s, hit_s;
    logic [5:0] dmg_sum_s;
    logic [4:0] dmg_sat_s;

    // Box overlap in 10 bits so positions near 511 cannot wrap; touching edges do not count.
    always_comb begin
        ox_s      = {1'b0, bus.Obj_X_Pos};
        oy_s      = {1'b0, bus.Obj_Y_Pos};
        ex_s      = {1'b0, bus.Enemy_X};
        ey_s      = {1'b0, bus.Enemy_Y};
        overlap_s = (ox_s < ex_s + 10'(ENEMY_SIZE)) && (ex_s < ox_s + 10'(PROJ_SIZE)) &&
                    (oy_s < ey_s + 10'(ENEMY_SIZE)) && (ey_s < oy_s + 10'(PROJ_SIZE));
        hit_s     = bus.Enemy_Alive & overlap_s;
        dmg_sum_s = 6'(DAMAGE_BASE) + {2'b00, bus.Game_Level};
        if (dmg_sum_s > 6'd31) begin
            dmg_sat_s = 5'd31;
        end else begin
            dmg_sat_s = dmg_sum_s[4:0];
        end
    end

    // Next-state and registered-output decode; the LOCK state is the per-projectile lockout.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pulse_d   = 1'b0;
        hit_idx_d = hit_idx_q;
        dmg_d     = dmg_q;
        case (state_q)
            IDLE: begin
                idx_d = {IDX_W{1'b0}};
                if (bus.game_frame_clk_rising_edge && bus.Obj_On) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (!bus.Obj_On) begin
                    state_d = IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end else if (hit_s) begin
                    state_d   = REPORT;
                    pulse_d   = 1'b1;
                    hit_idx_d = idx_q;
                    dmg_d     = dmg_sat_s;
                    idx_d     = {IDX_W{1'b0}};
                end else if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            REPORT: begin
                state_d = LOCK;
            end
            LOCK: begin
                if (!bus.Obj_On) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            hit_idx_q <= {IDX_W{1'b0}};
            pulse_q   <= 1'b0;
            dmg_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_idx_q <= hit_idx_d;
            pulse_q   <= pulse_d;
            dmg_q     <= dmg_d;
        end
    end

    assign bus.Enemy_Idx              = idx_q;
    assign bus.One_Enemy_Is_Attacked2 = pulse_q;
    assign bus.Enemy_Hit_Valid        = pulse_q;
    assign bus.Enemy_Hit_Idx          = hit_idx_q;
    assign bus.Enemy_Damage           = dmg_q;

`ifdef HIT_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum_s;

    // Score grows by the reported damage during REPORT, clamped at all-ones.
    always_comb begin
        score_sum_s = {1'b0, score_q} + {12'd0, dmg_q};
        if (state_q == REPORT) begin
            if (score_sum_s[16]) begin
                score_d = 16'hFFFF;
            end else begin
                score_d = score_sum_s[15:0];
            end
        end else begin
            score_d = score_q;
        end
    end

    // Score register, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.Score = score_q;
`else
    assign bus.Score = 16'd0;
`endif

endmodule

// File: tb/tb_attack2_hit_detector.sv
// Directed testbench for attack2_hit_detector with a behavioural enemy bank.
module tb_attack2_hit_detector;
    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    attack2_hit_detector_if #(.IDX_W(3)) bus ();

    attack2_hit_detector #(
        .NUM_ENEMIES(8), .IDX_W(3), .PROJ_SIZE(25), .ENEMY_SIZE(20), .DAMAGE_BASE(1)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    logic [8:0] bank_x [8];
    logic [8:0] bank_y [8];
    logic       bank_alive [8];

    assign bus.Enemy_X     = bank_x[bus.Enemy_Idx];
    assign bus.Enemy_Y     = bank_y[bus.Enemy_Idx];
    assign bus.Enemy_Alive = bank_alive[bus.Enemy_Idx];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_tick();
        bus.game_frame_clk_rising_edge = 1'b1;
        step();
        bus.game_frame_clk_rising_edge = 1'b0;
    endtask

    task automatic clear_bank();
        for (int i = 0; i < 8; i++) begin
            bank_x[i]     = 9'd0;
            bank_y[i]     = 9'd0;
            bank_alive[i] = 1'b0;
        end
    endtask

    task automatic set_slot(input int s, input logic [8:0] x, input logic [8:0] y);
        bank_x[s]     = x;
        bank_y[s]     = y;
        bank_alive[s] = 1'b1;
    endtask

    // Tick, then watch ncyc cycles recording pulse timing and the reported hit.
    task automatic run_frame(input int ncyc, output int first, output int npulse, output int nvalid,
                             output logic [2:0] hidx, output logic [4:0] dmg);
        first = -1; npulse = 0; nvalid = 0; hidx = 3'd0; dmg = 5'd0;
        frame_tick();
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (bus.One_Enemy_Is_Attacked2 === 1'b1) begin
                if (first < 0) first = c;
                npulse++;
            end
            if (bus.Enemy_Hit_Valid === 1'b1) begin
                nvalid++;
                hidx = bus.Enemy_Hit_Idx;
                dmg  = bus.Enemy_Damage;
            end
        end
    endtask

    task automatic check_frame(input string name, input int first, input int npulse, input int nvalid,
                               input logic [2:0] hidx, input logic [4:0] dmg,
                               input int e_first, input int e_n, input logic [2:0] e_hidx,
                               input logic [4:0] e_dmg);
        checks += 3;
        if (first !== e_first) begin
            failures++; $display("FAIL %s_latency: got %0d expected %0d", name, first, e_first);
        end
        if (npulse !== e_n) begin
            failures++; $display("FAIL %s_pulses: got %0d expected %0d", name, npulse, e_n);
        end
        if (nvalid !== e_n) begin
            failures++; $display("FAIL %s_valids: got %0d expected %0d", name, nvalid, e_n);
        end
        if (e_n > 0) begin
            checks += 2;
            if (hidx !== e_hidx) begin
                failures++; $display("FAIL %s_hit_idx: got %0d expected %0d", name, hidx, e_hidx);
            end
            if (dmg !== e_dmg) begin
                failures++; $display("FAIL %s_damage: got %0d expected %0d", name, dmg, e_dmg);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(); step();
        check_val("reset_idx", int'(bus.Enemy_Idx), 0);
        check_val("reset_pulse", int'(bus.One_Enemy_Is_Attacked2), 0);
        check_val("reset_valid", int'(bus.Enemy_Hit_Valid), 0);
        check_val("reset_hit_idx", int'(bus.Enemy_Hit_Idx), 0);
        check_val("reset_damage", int'(bus.Enemy_Damage), 0);
        check_val("reset_score", int'(bus.Score), 0);
        Reset = 1'b0;
        step();
    endtask

    task automatic test_single_hit();
        int f, n, v; logic [2:0] h; logic [4:0] d;
        clear_bank();
        set_slot(3, 9'd110, 9'd110);
        bus.Obj_X_Pos = 9'd100; bus.Obj_Y_Pos = 9'd100; bus.Game_Level = 4'd0; bus.Obj_On = 1'b1;
        run_frame(10, f, n, v, h, d);
        check_frame("single_hit", f, n, v, h, d, 4, 1, 3'd3, 5'd1);
        check_val("single_hit_hold_idx", int'(bus.Enemy_Hit_Idx), 3);
`ifdef HIT_SCORE_EN
        check_val("single_hit_score", int'(bus.Score), 1);
`else
        check_val("single_hit_score", int'(bus.Score), 0);
`endif
        bus.Obj_On = 1'b0; step();
    endtask

    task automatic test_touching_edge();
        int f, n, v; logic [2:0] h; logic [4:0] d;
        clear_bank();
        set_slot(2, 9'd125, 9'd100);
        set_slot(1, 9'd80, 9'd100);
        set_slot(4, 9'd100, 9'd125);
        bus.Obj_X_Pos = 9'd100; bus.Obj_Y_Pos = 9'd100; bus.Game_Level = 4'd0; bus.Obj_On = 1'b1;
        frame_tick();
        check_val("touch_scan_start_idx", int'(bus.Enemy_Idx), 0);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.One_Enemy_Is_Attacked2 === 1'b1) n++;
        end
        check_val("touch_scan_last_idx", int'(bus.Enemy_Idx), 7);
        step();
        if (bus.One_Enemy_Is_Attacked2 === 1'b1) n++;
        check_val("touch_no_pulse", n, 0);
        check_val("touch_idle_idx", int'(bus.Enemy_Idx), 0);
        bank_x[2] = 9'd124;
        run_frame(10, f, n, v, h, d);
        check_frame("touch_then_overlap", f, n, v, h, d, 3, 1, 3'd2, 5'd1);
        bus.Obj_On = 1'b0; step();
    endtask

    task automatic test_no_wrap();
        int f, n, v; logic [2:0] h; logic [4:0] d;
        clear_bank();
        set_slot(0, 9'd495, 9'd100);
        bus.Obj_X_Pos = 9'd500; bus.Obj_Y_Pos = 9'd100; bus.Game_Level = 4'd2; bus.Obj_On = 1'b1;
        run_frame(10, f, n, v, h, d);
        check_frame("no_wrap", f, n, v, h, d, 1, 1, 3'd0, 5'd3);
        bus.Obj_On = 1'b0; step();
    endtask

    task automatic test_lowest_index();
        int f, n, v; logic [2:0] h; logic [4:0] d;
        clear_bank();
        set_slot(1, 9'd90, 9'd90);
        set_slot(5, 9'd105, 9'd105);
        bus.Obj_X_Pos = 9'd100; bus.Obj_Y_Pos = 9'd100; bus.Game_Level = 4'd4; bus.Obj_On = 1'b1;
        run_frame(12, f, n, v, h, d);
        check_frame("lowest_index", f, n, v, h, d, 2, 1, 3'd1, 5'd5);
        bus.Obj_On = 1'b0; step();
    endtask

    task automatic test_lockout();
        int f, n, v; logic [2:0] h; logic [4:0] d;
        clear_bank();
        set_slot(6, 9'd100, 9'd100);
        bus.Obj_X_Pos = 9'd100; bus.Obj_Y_Pos = 9'd100; bus.Game_Level = 4'd0; bus.Obj_On = 1'b1;
        run_frame(10, f, n, v, h, d);
        check_frame("lock_first", f, n, v, h, d, 7, 1, 3'd6, 5'd1);
        for (int k = 0; k < 3; k++) begin
            run_frame(10, f, n, v, h, d);
            check_frame("lock_held", f, n, v, h, d, -1, 0, 3'd0, 5'd0);
        end
        check_val("lock_hold_hit_idx", int'(bus.Enemy_Hit_Idx), 6);
        bus.Obj_On = 1'b0; step();
        bus.Obj_On = 1'b1; step();
        run_frame(10, f, n, v, h, d);
        check_frame("lock_resume", f, n, v, h, d, 7, 1, 3'd6, 5'd1);
    endtask

    task automatic test_abort_and_reset();
        int n;
        clear_bank();
        set_slot(6, 9'd100, 9'd100);
        bus.Obj_X_Pos = 9'd100; bus.Obj_Y_Pos = 9'd100; bus.Game_Level = 4'd0; bus.Obj_On = 1'b1;
        bus.Obj_On = 1'b0; step();
        bus.Obj_On = 1'b1;
        frame_tick();
        step();
        bus.Obj_On = 1'b0;
        step();
        check_val("abort_idx", int'(bus.Enemy_Idx), 0);
        bus.Obj_On = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.One_Enemy_Is_Attacked2 === 1'b1 || bus.Enemy_Hit_Valid === 1'b1) n++;
        end
        check_val("abort_no_pulse", n, 0);
        frame_tick();
        step(); step(); step();
        check_val("pre_reset_idx", int'(bus.Enemy_Idx), 3);
        Reset = 1'b1;
        step();
        check_val("midscan_reset_idx", int'(bus.Enemy_Idx), 0);
        check_val("midscan_reset_pulse", int'(bus.One_Enemy_Is_Attacked2), 0);
        check_val("midscan_reset_valid", int'(bus.Enemy_Hit_Valid), 0);
        check_val("midscan_reset_hit_idx", int'(bus.Enemy_Hit_Idx), 0);
        check_val("midscan_reset_damage", int'(bus.Enemy_Damage), 0);
        check_val("midscan_reset_score", int'(bus.Score), 0);
        Reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.One_Enemy_Is_Attacked2 === 1'b1) n++;
        end
        check_val("post_reset_no_pulse", n, 0);
        bus.Obj_On = 1'b0; step();
    endtask

    task automatic hit_once(input logic [3:0] level);
        bus.Game_Level = level;
        bus.Obj_On = 1'b1;
        frame_tick();
        step(); step();
        bus.Obj_On = 1'b0;
        step();
    endtask

    task automatic test_score_saturation();
        int f, n, v, reps; logic [2:0] h; logic [4:0] d;
        clear_bank();
        set_slot(0, 9'd100, 9'd100);
        bus.Obj_X_Pos = 9'd100; bus.Obj_Y_Pos = 9'd100;
`ifdef HIT_SCORE_EN
        reps = 4095;
`else
        reps = 3;
`endif
        for (int i = 0; i < reps; i++) hit_once(4'd15);
        hit_once(4'd4);
`ifdef HIT_SCORE_EN
        check_val("score_preload", int'(bus.Score), 32'hFFF5);
`else
        check_val("score_preload", int'(bus.Score), 0);
`endif
        bus.Game_Level = 4'd15; bus.Obj_On = 1'b1;
        run_frame(4, f, n, v, h, d);
        check_frame("score_hit_l15", f, n, v, h, d, 1, 1, 3'd0, 5'd16);
`ifdef HIT_SCORE_EN
        check_val("score_saturate", int'(bus.Score), 32'hFFFF);
`else
        check_val("score_saturate", int'(bus.Score), 0);
`endif
        bus.Obj_On = 1'b0; step();
        hit_once(4'd15);
`ifdef HIT_SCORE_EN
        check_val("score_stays_saturated", int'(bus.Score), 32'hFFFF);
`else
        check_val("score_stays_saturated", int'(bus.Score), 0);
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        bus.game_frame_clk_rising_edge = 1'b0;
        bus.Obj_On = 1'b0;
        bus.Obj_X_Pos = 9'd0;
        bus.Obj_Y_Pos = 9'd0;
        bus.Game_Level = 4'd0;
        clear_bank();
        test_reset();
        test_single_hit();
        test_touching_edge();
        test_no_wrap();
        test_lowest_index();
        test_lockout();
        test_abort_and_reset();
        test_score_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
